// File: rtl/instr_mem_seq.sv
// Instruction memory with registered fetch, valid/ready handshake and program-load port.
// Macro-op expansion (busy, EXPAND state) is built only when INSTR_MACRO_EXPAND_EN is defined.
module instr_mem_seq #(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      DEPTH     = 512,
  parameter int unsigned      ADDR_W    = 32,
  parameter logic [WIDTH-1:0] STEP      = 32'h0010_0080,
  parameter logic [6:0]       MACRO_OPC = 7'b1000000,
  parameter string            INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_instr,
  output logic              rsp_err,
  input  logic              rsp_ready,
  output logic              busy,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WIDTH-1:0]  prog_data
);

  localparam int unsigned      IDX_W = $clog2(DEPTH);
  localparam logic [WIDTH-1:0] NOP   = WIDTH'(32'h0000_0013);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] mem_word;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             rd_err;
  logic             wr_ok;
  logic             accept;
  logic             beat;
  logic             idle;
  logic             gen_beat;

  // Power-up image only; reset never touches memory contents.
  initial for (int unsigned i = 0; i < DEPTH; i++) mem[i] = NOP;

  assign rd_idx   = req_addr[IDX_W+1:2];
  assign wr_idx   = prog_addr[IDX_W+1:2];
  assign rd_err   = (req_addr[1:0] != 2'b00) || (req_addr[ADDR_W-1:IDX_W+2] != '0);
  assign wr_ok    = (prog_addr[ADDR_W-1:IDX_W+2] == '0);
  assign mem_word = mem[rd_idx];

  assign req_ready = idle && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign beat      = rsp_valid && rsp_ready;

  always_ff @(posedge clk) begin
    if (prog_we && wr_ok) begin
      mem[wr_idx] <= prog_data;
    end
  end

  // Response register: loaded on accept, stepped on generated beats, held under back-pressure.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_instr <= NOP;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= rd_err;
      rsp_instr <= rd_err ? NOP : mem_word;
    end else if (gen_beat) begin
      rsp_instr <= rsp_instr + STEP;
    end else if (beat) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef INSTR_MACRO_EXPAND_EN
  typedef enum logic {IDLE, EXPAND} state_t;

  state_t     state;
  state_t     state_n;
  logic [4:0] count;
  logic [4:0] count_n;
  logic       busy_r;
  logic       busy_n;
  logic [4:0] macro_n;
  logic       is_macro;

  assign macro_n  = mem_word[19:15];
  assign is_macro = !rd_err && (mem_word[6:0] == MACRO_OPC) && (macro_n != '0);
  assign idle     = (state == IDLE);
  assign gen_beat = (state == EXPAND) && beat;
  assign busy     = busy_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      busy_r <= 1'b0;
    end else begin
      state  <= state_n;
      count  <= count_n;
      busy_r <= busy_n;
    end
  end

  // The final generated word is presented after returning to IDLE, so N+1 beats total.
  always_comb begin
    state_n = state;
    count_n = count;
    busy_n  = busy_r;
    case (state)
      IDLE: begin
        if (accept && is_macro) begin
          state_n = EXPAND;
          count_n = macro_n;
          busy_n  = 1'b1;
        end
      end
      EXPAND: begin
        if (beat) begin
          count_n = count - 5'd1;
          if (count == 5'd1) begin
            state_n = IDLE;
            busy_n  = 1'b0;
          end
        end
      end
      default: begin
        state_n = IDLE;
        count_n = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  logic unused;
  assign unused = ^{prog_addr[1:0]};
`else
  assign idle     = 1'b1;
  assign gen_beat = 1'b0;
  assign busy     = 1'b0;

  logic unused;
  assign unused = ^{prog_addr[1:0], STEP, MACRO_OPC};
`endif

endmodule

// File: tb/tb_instr_mem_seq.sv
// Self-checking bench for instr_mem_seq: transaction-queue reference model plus directed literals.
module tb_instr_mem_seq;

   localparam int unsigned W    = 32;
   localparam int unsigned D    = 64;
   localparam int unsigned AW   = 32;
   localparam logic [31:0] STEP = 32'h0010_0080;
   localparam logic [31:0] NOP  = 32'h0000_0013;
`ifdef INSTR_MACRO_EXPAND_EN
   localparam bit MACRO_ON = 1'b1;
`else
   localparam bit MACRO_ON = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req_valid = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic          req_ready;
   logic          rsp_valid;
   logic [W-1:0]  rsp_instr;
   logic          rsp_err;
   logic          rsp_ready = 1'b0;
   logic          busy;
   logic          prog_we = 1'b0;
   logic [AW-1:0] prog_addr = '0;
   logic [W-1:0]  prog_data = '0;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      logic [31:0] instr;
      logic        err;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_mem [D];
   logic [31:0] beats [5];

   always #5 clk = ~clk;

   instr_mem_seq #(
      .WIDTH (W),
      .DEPTH (D),
      .ADDR_W(AW),
      .STEP  (STEP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .req_valid(req_valid),
      .req_addr (req_addr),
      .req_ready(req_ready),
      .rsp_valid(rsp_valid),
      .rsp_instr(rsp_instr),
      .rsp_err  (rsp_err),
      .rsp_ready(rsp_ready),
      .busy     (busy),
      .prog_we  (prog_we),
      .prog_addr(prog_addr),
      .prog_data(prog_data)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // A fetch queues every word it will eventually present: the word itself, then its expansion.
   function automatic void push_fetch(input logic [31:0] addr);
      exp_t        e;
      logic [31:0] w;
      int unsigned n;
      if (addr[1:0] != 2'b00 || addr >= 4 * D) begin
         e.instr = NOP;
         e.err   = 1'b1;
         exp_q.push_back(e);
         return;
      end
      w       = m_mem[addr / 4];
      e.instr = w;
      e.err   = 1'b0;
      exp_q.push_back(e);
      n = w[19:15];
      if (MACRO_ON && w[6:0] == 7'h40 && n != 0) begin
         for (int unsigned k = 1; k <= n; k++) begin
            e.instr = w + k * STEP;
            exp_q.push_back(e);
         end
      end
   endfunction

   task automatic model_update();
      int unsigned sz      = exp_q.size();
      bit          m_ready = (sz == 0) || (sz == 1 && rsp_ready);
      bit          acc     = req_valid && m_ready;
      if (rst) begin
         exp_q.delete();
      end else begin
         if (sz != 0 && rsp_ready) void'(exp_q.pop_front());
         if (acc) push_fetch(req_addr);
      end
      if (prog_we && prog_addr < 4 * D) m_mem[prog_addr / 4] = prog_data;
   endtask

   task automatic compare();
      int unsigned sz = exp_q.size();
      chk("rsp_valid", rsp_valid, sz != 0);
      chk("req_ready", req_ready, (sz == 0) || (sz == 1 && rsp_ready));
      chk("busy", busy, MACRO_ON && sz > 1);
      if (sz != 0) begin
         chk("rsp_instr", rsp_instr, exp_q[0].instr);
         chk("rsp_err", rsp_err, exp_q[0].err);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_update();
      @(negedge clk);
      compare();
   endtask

   initial begin
      logic [31:0] d;
      for (int i = 0; i < int'(D); i++) m_mem[i] = NOP;
      beats[0] = 32'h0072_6140;
      beats[1] = 32'h0082_61C0;
      beats[2] = 32'h0092_6240;
      beats[3] = 32'h00A2_62C0;
      beats[4] = 32'h00B2_6340;

      // Reset state
      tick();
      tick();
      chk("reset_valid", rsp_valid, 1'b0);
      chk("reset_instr", rsp_instr, NOP);
      chk("reset_err", rsp_err, 1'b0);
      chk("reset_busy", busy, 1'b0);
      chk("reset_ready", req_ready, 1'b1);
      rst = 1'b0;

      // Load and back-to-back fetch
      prog_we = 1'b1; prog_addr = 0; prog_data = 32'h0000_0013;
      tick();
      prog_addr = 4; prog_data = 32'h0050_8093;
      tick();
      prog_we = 1'b0;
      req_valid = 1'b1; req_addr = 0; rsp_ready = 1'b1;
      tick();
      chk("fetch_w0", rsp_instr, 32'h0000_0013);
      req_addr = 4;
      tick();
      chk("fetch_w1", rsp_instr, 32'h0050_8093);
      req_valid = 1'b0;
      tick();

      // Back-pressure hold, then release accepts in the same cycle
      rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 4;
      tick();
      req_addr = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("hold_instr", rsp_instr, 32'h0050_8093);
         chk("hold_ready", req_ready, 1'b0);
      end
      rsp_ready = 1'b1;
      #1;
      chk("release_ready", req_ready, 1'b1);
      tick();
      chk("release_fetch", rsp_instr, 32'h0000_0013);
      req_valid = 1'b0;
      tick();

      // Macro word with N=4
      prog_we = 1'b1; prog_addr = 32; prog_data = 32'h0072_6140;
      tick();
      prog_we = 1'b0;
      req_valid = 1'b1; req_addr = 32;
      tick();
      req_valid = 1'b0;
`ifdef INSTR_MACRO_EXPAND_EN
      for (int k = 0; k < 5; k++) begin
         chk("macro_beat", rsp_instr, beats[k]);
         if (k < 4) chk("macro_busy", busy, 1'b1);
         tick();
      end
`else
      chk("macro_plain", rsp_instr, beats[0]);
      chk("macro_plain_busy", busy, 1'b0);
      tick();
`endif
      chk("macro_done", rsp_valid, 1'b0);

      // Reset during the third beat aborts the expansion
      req_valid = 1'b1; req_addr = 32;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      rst = 1'b1;
      tick();
      chk("abort_valid", rsp_valid, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_ready", req_ready, 1'b1);
      rst = 1'b0;
      req_valid = 1'b1; req_addr = 4;
      tick();
      chk("abort_refetch", rsp_instr, 32'h0050_8093);
      req_valid = 1'b0;
      tick();

      // Misaligned and out-of-range addresses
      req_valid = 1'b1; req_addr = 32'h802;
      tick();
      chk("err_mis", rsp_err, 1'b1);
      chk("err_mis_nop", rsp_instr, NOP);
      req_addr = 4 * D;
      tick();
      chk("err_range", rsp_err, 1'b1);
      chk("err_range_nop", rsp_instr, NOP);
      req_valid = 1'b0;
      tick();

      // Same-cycle write and read of one word returns the old contents
      prog_we = 1'b1; prog_addr = 12; prog_data = 32'hDEAD_BEEF;
      req_valid = 1'b1; req_addr = 12;
      tick();
      chk("rw_old", rsp_instr, NOP);
      prog_we = 1'b0;
      tick();
      chk("rw_new", rsp_instr, 32'hDEAD_BEEF);
      req_valid = 1'b0;
      tick();

      // Randomized traffic
      for (int c = 0; c < 4000; c++) begin
         rst       = ($urandom_range(0, 99) == 0);
         req_valid = ($urandom_range(0, 9) < 7);
         case ($urandom_range(0, 9))
            0:       req_addr = $urandom_range(0, 4 * D + 40);
            1:       req_addr = $urandom();
            default: req_addr = $urandom_range(0, 15) * 4;
         endcase
         rsp_ready = ($urandom_range(0, 9) < 7);
         prog_we   = ($urandom_range(0, 9) < 2);
         if ($urandom_range(0, 4) == 0) prog_addr = $urandom_range(0, 4 * D + 64);
         else prog_addr = $urandom_range(0, 15) * 4 + $urandom_range(0, 3);
         d = $urandom();
         if ($urandom_range(0, 2) == 0) begin
            d[6:0]   = 7'h40;
            d[19:15] = 5'($urandom_range(0, 3));
         end
         prog_data = d;
         tick();
      end

      rst = 1'b0; req_valid = 1'b0; prog_we = 1'b0; rsp_ready = 1'b1;
      for (int i = 0; i < 8; i++) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
